// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the play detector: FSM state encodings, default
// sizing constants and the one-hot test used to classify a filtered press.
package detector_jogada_pkg;

    typedef enum logic [1:0] {
        ESPERA   = 2'b00,
        SOLTURA  = 2'b01,
        BLOQUEIO = 2'b10
    } estado_t;

    localparam int N_BOTOES_PADRAO        = 4;
    localparam int DEBOUNCE_CICLOS_PADRAO = 20;

    // True when exactly one bit of v is set.
    function automatic logic eh_one_hot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/detector_jogada_debounce_bit.sv
// Single-button conditioner: two-flop synchroniser followed by a counter that
// only lets the filtered level follow the synced level after DEBOUNCE_CICLOS
// consecutive cycles of disagreement.
module debounce_bit #(
    parameter int DEBOUNCE_CICLOS = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic i_bruto,
    output logic o_filtrado
);
    localparam int CNT_W = $clog2(DEBOUNCE_CICLOS + 1);

    logic             r_sinc1;
    logic             r_sinc2;
    logic             r_filtrado;
    logic [CNT_W-1:0] r_cnt;

    // Two-stage synchroniser for the asynchronous pushbutton.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sinc1 <= 1'b0;
            r_sinc2 <= 1'b0;
        end else begin
            r_sinc1 <= i_bruto;
            r_sinc2 <= r_sinc1;
        end
    end

    // Count consecutive mismatch cycles; flip the filtered level on the last one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_filtrado <= 1'b0;
        end else if (r_sinc2 == r_filtrado) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CICLOS - 1)) begin
            r_cnt      <= '0;
            r_filtrado <= r_sinc2;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_filtrado = r_filtrado;

endmodule

// File: rtl/detector_jogada.sv
// Play detector: debounces every pushbutton and turns one clean press into a
// registered one-hot play with a single-cycle jogada_feita pulse.
// Optional macro DETECTOR_JOGADA_PRIORIDADE_EN: multi-button presses resolve to
// the lowest-index button instead of raising jogada_invalida.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ESPERA   | idle, waiting for any filtered button to go high
// SOLTURA  | press consumed (valid or rejected), waiting for all released
// BLOQUEIO | press arrived with habilita=0, ignored until all released
module detector_jogada
    import detector_jogada_pkg::*;
#(
    parameter int N_BOTOES        = N_BOTOES_PADRAO,
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                habilita,
    input  logic                zera,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] jogada,
    output logic                jogada_feita,
    output logic                jogada_invalida,
    output logic [N_BOTOES-1:0] db_filtrados,
    output logic [1:0]          db_estado
);

    logic [N_BOTOES-1:0] w_filt;
    logic                w_um_so;

    estado_t             r_estado;
    logic [N_BOTOES-1:0] r_jogada;
    logic                r_feita;
    logic                r_invalida;

    genvar g;
    generate
        for (g = 0; g < N_BOTOES; g++) begin : g_db
            debounce_bit #(
                .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
            ) u_db (
                .clock      (clock),
                .reset      (reset),
                .i_bruto    (botoes[g]),
                .o_filtrado (w_filt[g])
            );
        end
    endgenerate

    assign w_um_so = eh_one_hot(32'(w_filt));

`ifdef DETECTOR_JOGADA_PRIORIDADE_EN
    logic [N_BOTOES-1:0] w_menor;
    // Isolate the lowest set bit (two's-complement trick).
    assign w_menor = w_filt & (~w_filt + N_BOTOES'(1));
`endif

    // Press classification FSM with registered play and pulse outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado   <= ESPERA;
            r_jogada   <= '0;
            r_feita    <= 1'b0;
            r_invalida <= 1'b0;
        end else begin
            r_feita    <= 1'b0;
            r_invalida <= 1'b0;
            // Clear first so a capture on the same edge overrides it.
            if (zera) begin
                r_jogada <= '0;
            end
            case (r_estado)
                ESPERA: begin
                    if (w_filt != '0) begin
                        if (!habilita) begin
                            r_estado <= BLOQUEIO;
                        end else if (w_um_so) begin
                            r_jogada <= w_filt;
                            r_feita  <= 1'b1;
                            r_estado <= SOLTURA;
                        end else begin
`ifdef DETECTOR_JOGADA_PRIORIDADE_EN
                            r_jogada <= w_menor;
                            r_feita  <= 1'b1;
`else
                            r_invalida <= 1'b1;
`endif
                            r_estado <= SOLTURA;
                        end
                    end
                end
                SOLTURA, BLOQUEIO: begin
                    if (w_filt == '0) begin
                        r_estado <= ESPERA;
                    end
                end
                default: r_estado <= ESPERA;
            endcase
        end
    end

    assign jogada          = r_jogada;
    assign jogada_feita    = r_feita;
    assign jogada_invalida = r_invalida;
    assign db_filtrados    = w_filt;
    assign db_estado       = r_estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Scoreboard bench for detector_jogada with DEBOUNCE_CICLOS=4 (1 ms clock).
`timescale 1us/1ns
module tb_detector_jogada;

    localparam int D   = 4;
    localparam int LAT = D + 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic       zera;
    logic [3:0] botoes;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       jogada_invalida;
    logic [3:0] db_filtrados;
    logic [1:0] db_estado;

    typedef struct {
        bit         inv;
        logic [3:0] jog;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    detector_jogada #(
        .N_BOTOES        (4),
        .DEBOUNCE_CICLOS (D)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .habilita        (habilita),
        .zera            (zera),
        .botoes          (botoes),
        .jogada          (jogada),
        .jogada_feita    (jogada_feita),
        .jogada_invalida (jogada_invalida),
        .db_filtrados    (db_filtrados),
        .db_estado       (db_estado)
    );

    always #500 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_total++;
        if (atual === esperado) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, esperado, cyc);
    endtask

    task automatic espera_pulso(input bit inv, input logic [3:0] jog);
        exp_t e;
        e.inv = inv;
        e.jog = jog;
        e.cyc = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic ciclos(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: every pulse seen on the outputs must match the next scoreboard entry.
    always @(negedge clock) begin
        if (reset === 1'b1 && (jogada_feita || jogada_invalida)) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_pulse: feita=%0b invalida=%0b jogada=%b cycle %0d",
                         jogada_feita, jogada_invalida, jogada, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({jogada_feita, jogada_invalida} === {~e.inv, e.inv} &&
                    jogada === e.jog && cyc == e.cyc) begin
                    n_pass++;
                end else begin
                    $display("FAIL pulse: got feita=%0b invalida=%0b jogada=%b cycle %0d, expected inv=%0b jogada=%b cycle %0d",
                             jogada_feita, jogada_invalida, jogada, cyc, e.inv, e.jog, e.cyc);
                end
            end
        end
    end

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] jog_apos_multi;
        reset    = 1'b0;
        habilita = 1'b0;
        zera     = 1'b0;
        botoes   = 4'b0000;
        ciclos(3);
        check("reset_jogada",   32'(jogada), 32'h0);
        check("reset_pulses",   32'({jogada_feita, jogada_invalida}), 32'h0);
        check("reset_filtered", 32'(db_filtrados), 32'h0);
        check("reset_state",    32'(db_estado), 32'h0);
        reset    = 1'b1;
        habilita = 1'b1;
        ciclos(3);

        // Clean single press, held long: one pulse only, release latency.
        botoes = 4'b0100;
        espera_pulso(1'b0, 4'b0100);
        ciclos(20);
        check("clean_jogada", 32'(jogada), 32'h4);
        check("clean_state_held", 32'(db_estado), 32'h1);
        botoes = 4'b0000;
        ciclos(LAT - 1);
        check("release_state_early", 32'(db_estado), 32'h1);
        ciclos(1);
        check("release_state_espera", 32'(db_estado), 32'h0);
        ciclos(4);

        // Bouncing button: only the final stable hold is accepted.
        for (int i = 0; i < 6; i++) begin
            botoes = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            ciclos(2);
        end
        check("bounce_filtered", 32'(db_filtrados), 32'h0);
        botoes = 4'b0010;
        espera_pulso(1'b0, 4'b0010);
        ciclos(12);
        check("bounce_jogada", 32'(jogada), 32'h2);
        botoes = 4'b0000;
        ciclos(12);

        // Simultaneous press.
`ifdef DETECTOR_JOGADA_PRIORIDADE_EN
        jog_apos_multi = 4'b0001;
        botoes = 4'b0011;
        espera_pulso(1'b0, 4'b0001);
`else
        jog_apos_multi = 4'b0010;
        botoes = 4'b0011;
        espera_pulso(1'b1, 4'b0010);
`endif
        ciclos(12);
        check("multi_jogada", 32'(jogada), 32'(jog_apos_multi));
        botoes = 4'b0000;
        ciclos(12);

        // Press while disabled, enabling mid-hold changes nothing.
        habilita = 1'b0;
        botoes   = 4'b1000;
        ciclos(8);
        habilita = 1'b1;
        ciclos(5);
        check("disabled_state", 32'(db_estado), 32'h2);
        check("disabled_jogada", 32'(jogada), 32'(jog_apos_multi));
        botoes = 4'b0000;
        ciclos(LAT);
        check("disabled_release_state", 32'(db_estado), 32'h0);
        botoes = 4'b1000;
        espera_pulso(1'b0, 4'b1000);
        ciclos(12);
        check("reenabled_jogada", 32'(jogada), 32'h8);
        botoes = 4'b0000;
        ciclos(12);

        // Reset mid-press, then the held button counts as a new press.
        botoes = 4'b0001;
        ciclos(3);
        reset = 1'b0;
        #1;
        check("midreset_jogada", 32'(jogada), 32'h0);
        check("midreset_filtered", 32'(db_filtrados), 32'h0);
        check("midreset_state", 32'(db_estado), 32'h0);
        ciclos(2);
        reset = 1'b1;
        espera_pulso(1'b0, 4'b0001);
        ciclos(12);
        check("postreset_jogada", 32'(jogada), 32'h1);
        botoes = 4'b0000;
        ciclos(12);

        // Synchronous clear with no pulse.
        zera = 1'b1;
        ciclos(1);
        zera = 1'b0;
        check("zera_jogada", 32'(jogada), 32'h0);
        ciclos(3);

        // Clear coinciding with a capture: the capture wins.
        botoes = 4'b0100;
        espera_pulso(1'b0, 4'b0100);
        ciclos(LAT - 1);
        zera = 1'b1;
        ciclos(1);
        zera = 1'b0;
        check("zera_vs_capture", 32'(jogada), 32'h4);
        botoes = 4'b0000;
        ciclos(12);

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/detector_jogada.md
Name: detector_jogada

Overview:
- Input conditioner directly upstream of the memory-game top level. Drives its `botoes` play bus.
- Takes the raw pushbuttons and synchronises and debounces each one.
- Converts one clean press into a registered one-hot play plus a single-cycle `jogada_feita` pulse for the game control unit.
- Rejects simultaneous multi-button presses and presses made while plays are not enabled.

Parameters:
- N_BOTOES, 4, number of buttons; width of the play bus.
- DEBOUNCE_CICLOS, 20, consecutive stable cycles required before a filtered level changes (20 ms at the 1 kHz game clock); minimum 2.
- CNT_W, $clog2(DEBOUNCE_CICLOS+1), debounce counter width; derived, not overridden.

Ports:
- clock  input  1  system clock (1 kHz in the game).
- reset  input  1  asynchronous, active-low reset (0 = reset).
- habilita  input  1  from control unit; 1 = plays are accepted.
- zera  input  1  synchronous clear of `jogada`.
- botoes  input  N_BOTOES  raw, asynchronous pushbuttons, active-high.
- jogada  output  N_BOTOES  registered one-hot last valid play.
- jogada_feita  output  1  one-cycle pulse: a new valid play is on `jogada`.
- jogada_invalida  output  1  one-cycle pulse: a multi-button press was rejected.
- db_filtrados  output  N_BOTOES  debounced button levels.
- db_estado  output  2  FSM state encoding.

Behaviour:
- Reset (reset=0, asynchronous):
  - Sync FFs, filtered bits and counters go to 0.
  - FSM goes to ESPERA.
  - jogada=0, jogada_feita=0, jogada_invalida=0.
- Synchroniser: each botoes bit passes through 2 flip-flops before any other logic.
- Debounce, per bit:
  - Counter resets to 0 whenever the synced value equals the filtered value.
  - Otherwise it increments.
  - The filtered bit takes the synced value on the edge where mismatch has persisted DEBOUNCE_CICLOS consecutive cycles; the counter resets on that same edge.
  - Any glitch shorter than DEBOUNCE_CICLOS cycles never reaches the filtered bit.
- FSM states: ESPERA=2'b00, SOLTURA=2'b01, BLOQUEIO=2'b10.
- ESPERA:
  - filtered==0: stay.
  - filtered has exactly one bit set and habilita=1: on the next edge, jogada<=filtered, pulse jogada_feita, go to SOLTURA.
  - filtered has more than one bit set and habilita=1: pulse jogada_invalida, jogada unchanged, go to SOLTURA.
  - filtered!=0 and habilita=0: go to BLOQUEIO, no pulse.
- SOLTURA and BLOQUEIO:
  - Wait for filtered==0, then go to ESPERA on the next edge.
  - Further presses of other buttons are ignored.
  - habilita changes are ignored.
- Latency: raw rising edge held stable → jogada_feita high exactly DEBOUNCE_CICLOS+3 edges later (2 sync + DEBOUNCE_CICLOS + 1 output register). Release → ESPERA after DEBOUNCE_CICLOS+3 edges.
- Pulse widths: jogada_feita and jogada_invalida are each high exactly one cycle and never high together.
- Holding a button produces one play only; there is no autorepeat.
- zera=1: jogada<=0 on that edge, in any state. If zera coincides with a valid capture, the capture wins: jogada=new play and jogada_feita pulses.
- Presses landing on the same filtered edge count as simultaneous. Presses staggered by at least one filtered edge: the first press wins and later ones are ignored.
- Reset mid-press: outputs clear immediately. After reset release with a button still held, filtered rises after DEBOUNCE_CICLOS+2 edges and is treated as a new press under the ESPERA rules.
- All outputs are registered; there is no combinational path from botoes to any output.

Optional Feature:
- Macro: DETECTOR_JOGADA_PRIORIDADE_EN.
- Defined: a multi-bit press in ESPERA with habilita=1 is resolved to the lowest-index set bit. That bit is captured as a valid play with a jogada_feita pulse; jogada_invalida is tied to 0.
- Undefined: multi-bit presses are rejected as specified above.

Decomposition:
- Shared package detector_jogada_pkg holds:
  - the state encodings ESPERA/SOLTURA/BLOQUEIO;
  - the default N_BOTOES and DEBOUNCE_CICLOS constants;
  - a one-hot check function.
- One sub-module, debounce_bit: 2-FF synchroniser, counter and filtered bit for a single button, parameterised by DEBOUNCE_CICLOS.
- debounce_bit is instantiated N_BOTOES times in a generate loop.

Test Plan (DEBOUNCE_CICLOS=4, clock period 1 ms):
- Single valid press, clean. Reset, habilita=1, botoes=4'b0100 held for 20 cycles, then 0 → jogada=4'b0100 and jogada_feita pulses exactly once, 7 edges after the press. FSM is back in ESPERA 7 edges after release.
- Bounce. Toggle botoes[1] every 2 cycles for 10 cycles, then hold 1 → no pulse during toggling. jogada_feita fires 7 edges after the stable hold begins; jogada=4'b0010.
- Simultaneous press. botoes=4'b0011 asserted together → jogada_invalida pulses once and jogada keeps its prior value. With DETECTOR_JOGADA_PRIORIDADE_EN defined, instead jogada=4'b0001 and jogada_feita pulses.
- Disabled press. habilita=0, press botoes[3], then set habilita=1 while still held → no pulse and db_estado=2'b10. After release plus 7 edges, a new press of botoes[3] gives jogada=4'b1000.
- Reset and clear. Assert reset=0 mid-press → all outputs 0 immediately. Then zera=1 after a capture of 4'b0001 → jogada=0 on the next edge, with no pulse.
